// File: rtl/rv32i_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rv32i_dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   cpu_*  : MEM-stage request (req/we/be/addr/wdata in, stall/rvalid/rdata out)
//   ext_*  : external requester (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   d_*    : RAM data port (we/be/addr/wdata out, rdata in, 1-cycle latency)
// Modports:
//   slave  : the arbiter itself
//   master : the environment (MEM stage, external requester and RAM)
// ---------------------------------------------------------------------------
interface rv32i_dmem_arbiter_if;
  // MEM stage
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  // External requester
  logic        ext_req;
  logic        ext_we;
  logic [3:0]  ext_be;
  logic [29:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  // RAM data port
  logic        d_we;
  logic [3:0]  d_be;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_be, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output d_we, d_be, d_addr, d_wdata,
    input  d_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_be, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  d_we, d_be, d_addr, d_wdata,
    output d_rdata
  );
endinterface

// File: rtl/rv32i_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_dmem_arbiter
// Shares the RAM data port between the MEM stage (default priority) and an
// external requester. After STARVE_LIMIT consecutive denied ext cycles the
// external requester wins the next conflict and the MEM stage is stalled.
// Read data from the 1-cycle-latency RAM is routed back to whichever
// requester issued the read in the previous cycle.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : rv32i_dmem_arbiter_if.slave (cpu_*, ext_*, d_* signals)
// Parameter:
//   STARVE_LIMIT (0..15): denied ext cycles before ext wins a conflict;
//                         0 means ext always wins.
// ---------------------------------------------------------------------------
module rv32i_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32i_dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT
  } owner_e;

  logic [3:0] starve_q, starve_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       ext_pri;
  logic       cpu_gnt;
  logic       ext_gnt;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= 4'd0;
      rd_owner_q <= OWN_NONE;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Grant decision and next state.
  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    ext_pri    = (starve_q >= LIMIT);
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    starve_d   = 4'd0;
    rd_owner_d = OWN_NONE;

    // Nothing is granted while reset is held, so no access reaches the RAM.
    if (!reset) begin
      if (bus.cpu_req && bus.ext_req) begin
        cpu_gnt = !ext_pri;
        ext_gnt = ext_pri;
      end else begin
        cpu_gnt = bus.cpu_req;
        ext_gnt = bus.ext_req;
      end
    end

    // Count consecutive denied ext cycles; saturate so the count can never
    // wrap back into CPU priority while ext keeps waiting.
    if (bus.ext_req && !ext_gnt) begin
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end

    // Remember who owns the read data that the RAM returns next cycle.
    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (ext_gnt && !bus.ext_we) begin
      rd_owner_d = OWN_EXT;
    end
  end

  // Outputs: RAM port mux, handshakes and read-data routing.
  always_comb begin
    bus.d_we       = 1'b0;
    bus.d_be       = 4'd0;
    bus.d_addr     = 30'd0;
    bus.d_wdata    = 32'd0;
    bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !reset;
    bus.ext_gnt    = ext_gnt;
    bus.cpu_rvalid = 1'b0;
    bus.cpu_rdata  = 32'd0;
    bus.ext_rvalid = 1'b0;
    bus.ext_rdata  = 32'd0;

    if (cpu_gnt) begin
      bus.d_we    = bus.cpu_we;
      bus.d_be    = bus.cpu_be;
      bus.d_addr  = bus.cpu_addr;
      bus.d_wdata = bus.cpu_wdata;
    end else if (ext_gnt) begin
      bus.d_we    = bus.ext_we;
      bus.d_be    = bus.ext_be;
      bus.d_addr  = bus.ext_addr;
      bus.d_wdata = bus.ext_wdata;
    end

    // rd_owner_q still holds a pre-reset read during the first reset
    // cycle; gating with reset keeps that return from being reported.
    if (!reset && rd_owner_q == OWN_CPU) begin
      bus.cpu_rvalid = 1'b1;
      bus.cpu_rdata  = bus.d_rdata;
    end
    if (!reset && rd_owner_q == OWN_EXT) begin
      bus.ext_rvalid = 1'b1;
      bus.ext_rdata  = bus.d_rdata;
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_dmem_arbiter
// Drives the arbiter with directed scenarios followed by randomized traffic,
// attaches a byte-enabled RAM with 1-cycle read latency, and compares every
// output each cycle against a transaction-level reference model (starvation
// count, pending read owner/data and a shadow copy of memory).
// ---------------------------------------------------------------------------
module tb_rv32i_dmem_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic        rst;
    logic        cr;
    logic        cw;
    logic [3:0]  cb;
    logic [29:0] ca;
    logic [31:0] cd;
    logic        er;
    logic        ew;
    logic [3:0]  eb;
    logic [29:0] ea;
    logic [31:0] ed;
  } stim_t;

  logic clk;
  logic reset;
  rv32i_dmem_arbiter_if bus ();

  rv32i_dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read port.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (bus.d_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.d_be[b]) ram[bus.d_addr[7:0]][8*b +: 8] <= bus.d_wdata[8*b +: 8];
      end
    end
    bus.d_rdata <= ram[bus.d_addr[7:0]];
  end

  // Reference model state.
  logic [31:0] shadow [256];
  int          m_starve;
  int          m_pend;      // 0 = none, 1 = cpu, 2 = ext
  logic [31:0] m_pdata;
  logic        hold_cpu;
  logic        hold_ext;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, cr: 1'b0, cw: 1'b0, cb: 4'h0, ca: 30'd0, cd: 32'd0,
          er: 1'b0, ew: 1'b0, eb: 4'h0, ea: 30'd0, ed: 32'd0};
    return s;
  endfunction

  // One clock cycle: apply stimulus after the edge, check the DUT against
  // the model, then advance the model to the next cycle.
  task automatic do_cycle(input stim_t s);
    logic        cg, eg, ext_wins;
    logic        x_we;
    logic [3:0]  x_be;
    logic [29:0] x_addr;
    logic [31:0] x_wd;
    @(posedge clk);
    #1;
    reset         = s.rst;
    bus.cpu_req   = s.cr;  bus.cpu_we = s.cw;  bus.cpu_be = s.cb;
    bus.cpu_addr  = s.ca;  bus.cpu_wdata = s.cd;
    bus.ext_req   = s.er;  bus.ext_we = s.ew;  bus.ext_be = s.eb;
    bus.ext_addr  = s.ea;  bus.ext_wdata = s.ed;
    #1;

    ext_wins = (m_starve >= LIMIT);
    cg = !s.rst && s.cr && (!s.er || !ext_wins);
    eg = !s.rst && s.er && (!s.cr || ext_wins);
    x_we = 1'b0; x_be = 4'h0; x_addr = 30'd0; x_wd = 32'd0;
    if (cg) begin x_we = s.cw; x_be = s.cb; x_addr = s.ca; x_wd = s.cd; end
    if (eg) begin x_we = s.ew; x_be = s.eb; x_addr = s.ea; x_wd = s.ed; end

    check("cpu_stall",  32'(bus.cpu_stall),  32'(s.cr && !cg && !s.rst));
    check("ext_gnt",    32'(bus.ext_gnt),    32'(eg));
    check("d_we",       32'(bus.d_we),       32'(x_we));
    check("d_be",       32'(bus.d_be),       32'(x_be));
    check("d_addr",     32'(bus.d_addr),     32'(x_addr));
    check("d_wdata",    bus.d_wdata,         x_wd);
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!s.rst && m_pend == 1));
    check("cpu_rdata",  bus.cpu_rdata,       (!s.rst && m_pend == 1) ? m_pdata : 32'd0);
    check("ext_rvalid", 32'(bus.ext_rvalid), 32'(!s.rst && m_pend == 2));
    check("ext_rdata",  bus.ext_rdata,       (!s.rst && m_pend == 2) ? m_pdata : 32'd0);

    if (s.rst) begin
      m_starve = 0;
      m_pend   = 0;
    end else begin
      m_starve = (s.er && !eg) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
      m_pend   = (cg && !s.cw) ? 1 : (eg && !s.ew) ? 2 : 0;
      m_pdata  = shadow[x_addr[7:0]];
      if ((cg || eg) && x_we) shadow[x_addr[7:0]] = merge(shadow[x_addr[7:0]], x_wd, x_be);
    end
    hold_cpu = !s.rst && s.cr && !cg;
    hold_ext = !s.rst && s.er && !eg;
  endtask

  stim_t s;
  logic [9:0] pat10;
  logic [4:0] pat5;

  initial begin
    checks = 0; errors = 0;
    m_starve = 0; m_pend = 0; m_pdata = 32'd0;
    hold_cpu = 1'b0; hold_ext = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = 4'h0; bus.cpu_addr = 30'd0;
    bus.cpu_wdata = 32'd0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_be = 4'h0; bus.ext_addr = 30'd0;
    bus.ext_wdata = 32'd0;

    // Reset with both requesting: nothing may be granted or stalled.
    s = idle(); s.rst = 1'b1; s.cr = 1'b1; s.cw = 1'b1; s.cb = 4'hF; s.er = 1'b1;
    do_cycle(s);
    do_cycle(s);
    check("rst_d_we", 32'(bus.d_we), 32'd0);
    do_cycle(idle());

    // Single cpu read of 0x10.
    s = idle(); s.cr = 1'b1; s.ca = 30'h10;
    do_cycle(s);
    check("t1_d_addr", 32'(bus.d_addr), 32'h10);
    do_cycle(idle());
    check("t1_cpu_rdata", bus.cpu_rdata, init_word(16));

    // ext full-word write to 0x20, then cpu reads it back.
    s = idle(); s.er = 1'b1; s.ew = 1'b1; s.eb = 4'hF; s.ea = 30'h20; s.ed = 32'hDEADBEEF;
    do_cycle(s);
    check("t2_d_wdata", bus.d_wdata, 32'hDEADBEEF);
    s = idle(); s.cr = 1'b1; s.ca = 30'h20;
    do_cycle(s);
    check("t2_no_rvalid", 32'(bus.ext_rvalid), 32'd0);
    do_cycle(idle());
    check("t2_readback", bus.cpu_rdata, 32'hDEADBEEF);

    // Alternating owners: cpu read 0x04 then ext read 0x08.
    s = idle(); s.cr = 1'b1; s.ca = 30'h04;
    do_cycle(s);
    s = idle(); s.er = 1'b1; s.ea = 30'h08;
    do_cycle(s);
    check("t4_cpu_rdata", bus.cpu_rdata, init_word(4));
    do_cycle(idle());
    check("t4_ext_rdata", bus.ext_rdata, init_word(8));
    check("t4_cpu_quiet", 32'(bus.cpu_rvalid), 32'd0);

    // Continuous conflict: ext wins at cycles 4 and 9.
    s = idle(); s.cr = 1'b1; s.ca = 30'h1; s.er = 1'b1; s.ea = 30'h2;
    for (int i = 0; i < 10; i++) begin
      do_cycle(s);
      pat10[i] = bus.ext_gnt;
    end
    check("t3_ext_pattern", 32'(pat10), 32'h210);
    do_cycle(idle());

    // Starvation count clears when ext drops its request.
    s = idle(); s.cr = 1'b1; s.ca = 30'h3; s.er = 1'b1; s.ea = 30'h5;
    for (int i = 0; i < 3; i++) do_cycle(s);
    s.er = 1'b0;
    do_cycle(s);
    s.er = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_cycle(s);
      pat5[i] = bus.ext_gnt;
    end
    check("t6_ext_pattern", 32'(pat5), 32'h10);
    do_cycle(idle());

    // Read granted just before reset must not return.
    s = idle(); s.cr = 1'b1; s.ca = 30'h3;
    do_cycle(s);
    s = idle(); s.rst = 1'b1; s.cr = 1'b1; s.cw = 1'b1; s.cb = 4'hF; s.ca = 30'h3;
    do_cycle(s);
    check("t5_rvalid_rst", 32'(bus.cpu_rvalid), 32'd0);
    check("t5_d_we_rst", 32'(bus.d_we), 32'd0);
    do_cycle(idle());
    check("t5_rvalid_after", 32'(bus.cpu_rvalid), 32'd0);

    // Randomized traffic honouring the hold-until-accepted rule.
    s = idle();
    for (int n = 0; n < 600; n++) begin
      s.rst = ($urandom_range(0, 59) == 0);
      if (!hold_cpu) begin
        s.cr = ($urandom_range(0, 9) < 6);
        s.cw = ($urandom_range(0, 2) == 0);
        s.cb = 4'($urandom_range(0, 15));
        s.ca = 30'($urandom_range(0, 15));
        s.cd = $urandom;
      end
      if (!hold_ext) begin
        s.er = ($urandom_range(0, 9) < 5);
        s.ew = ($urandom_range(0, 2) == 0);
        s.eb = 4'($urandom_range(0, 15));
        s.ea = 30'($urandom_range(0, 15));
        s.ed = $urandom;
      end
      do_cycle(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
